// File: rtl/alu_pkg.sv
// Types and helpers shared by the serial ALU receive path and its scoreboard.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } pkt_type_t;

    localparam int         PKT_BITS     = 11;
    localparam int         CRC_MSG_BITS = 68;
    localparam logic [3:0] CRC_POLY     = 4'h3;  // x^4 + x + 1, x^4 term implicit

    // CRC-4, init 0, MSB first over {B, A, 1'b1, op}.
    function automatic logic [3:0] crc4_calc(input logic [CRC_MSG_BITS-1:0] msg);
        logic [3:0] crc;
        crc = 4'h0;
        for (int i = CRC_MSG_BITS - 1; i >= 0; i--) begin
            if (crc[3] ^ msg[i]) crc = {crc[2:0], 1'b0} ^ CRC_POLY;
            else                 crc = {crc[2:0], 1'b0};
        end
        return crc;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/alu_rx_packet.sv
// Packet deserializer: start detect, type + payload shift, stop-bit check.
module alu_rx_packet
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin_i,
    output logic       pkt_done_o,
    output pkt_type_t  pkt_type_o,
    output logic [7:0] payload_o,
    output logic       stop_ok_o,
    output logic       idle_o
);

    typedef enum logic {PK_IDLE, PK_BITS} pk_state_t;
    localparam logic [3:0] STOP_IDX = 4'(PKT_BITS - 1);

    pk_state_t  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] shift_q, shift_d;  // {type, payload}

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PK_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pkt_done_o = 1'b0;
        case (state_q)
            PK_IDLE: begin
                if (!sin_i) begin
                    state_d   = PK_BITS;
                    bit_cnt_d = 4'd1;
                end
            end
            PK_BITS: begin
                // Stop bit is on sin this cycle; report it without shifting.
                if (bit_cnt_q == STOP_IDX) begin
                    pkt_done_o = 1'b1;
                    state_d    = PK_IDLE;
                    bit_cnt_d  = '0;
                end else begin
                    shift_d   = {shift_q[7:0], sin_i};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = PK_IDLE;
        endcase
    end

    assign pkt_type_o = pkt_type_t'(shift_q[8]);
    assign payload_o  = shift_q[7:0];
    assign stop_ok_o  = sin_i;
    assign idle_o     = (state_q == PK_IDLE);

endmodule

// File: rtl/alu_serial_rx.sv
// Frame assembler/checker: collects data + ctl packets, checks framing, CRC and
// opcode, and emits one decoded command or one error pulse per frame.
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int unsigned DATA_PACKETS = 8,
    parameter int unsigned IDLE_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        frame_valid,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        busy
);

    localparam int         IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [3:0] N_DATA  = 4'(DATA_PACKETS);
    localparam logic [3:0] CNT_SAT = 4'(DATA_PACKETS + 1);

    typedef enum logic [1:0] {F_IDLE, F_COLLECT, F_REPORT} frame_state_t;

    logic       pkt_done, pkt_stop_ok, pk_idle;
    pkt_type_t  pkt_type;
    logic [7:0] pkt_payload;

    alu_rx_packet u_pkt (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_i      (sin),
        .pkt_done_o (pkt_done),
        .pkt_type_o (pkt_type),
        .payload_o  (pkt_payload),
        .stop_ok_o  (pkt_stop_ok),
        .idle_o     (pk_idle)
    );

    frame_state_t      state_q, state_d;
    logic [7:0][7:0]   data_q;  // [7] = B[31:24] ... [0] = A[7:0]
    logic [3:0]        data_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              bad_q;
    logic [31:0]       a_q, b_q;
    operation_t        op_q;
    logic              fv_q, ed_q, ec_q, eo_q;
    logic              fv_d, ed_d, ec_d, eo_d;

    logic       pk_start, data_pkt, ctl_pkt, idle_tick, timeout, frame_start;
    logic [2:0] ctl_op, byte_idx;
    logic [3:0] ctl_crc, crc_calc;
    logic       unused_ctl_msb;

    assign pk_start       = pk_idle & ~sin;
    assign data_pkt       = (state_q == F_COLLECT) & pkt_done & (pkt_type == PKT_DATA);
    assign ctl_pkt        = (state_q == F_COLLECT) & pkt_done & (pkt_type == PKT_CTL);
    assign idle_tick      = (state_q == F_COLLECT) & pk_idle & sin;
    assign timeout        = idle_tick & (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
    assign ctl_op         = pkt_payload[6:4];
    assign ctl_crc        = pkt_payload[3:0];
    assign unused_ctl_msb = pkt_payload[7];
    assign byte_idx       = data_cnt_q[2:0];
    assign crc_calc       = crc4_calc({data_q, 1'b1, ctl_op});

    always_comb begin
        state_d = state_q;
        fv_d = 1'b0;
        ed_d = 1'b0;
        ec_d = 1'b0;
        eo_d = 1'b0;
        case (state_q)
            F_IDLE:    if (pk_start) state_d = F_COLLECT;
            F_COLLECT: begin
                if (ctl_pkt)      state_d = F_REPORT;
                else if (timeout) state_d = F_IDLE;
            end
            // A back-to-back frame may start during the report cycle.
            F_REPORT:  state_d = pk_start ? F_COLLECT : F_IDLE;
            default:   state_d = F_IDLE;
        endcase
        if (ctl_pkt) begin
            if (bad_q || (data_cnt_q != N_DATA) || !pkt_stop_ok) ed_d = 1'b1;
            else if (ctl_crc != crc_calc)                        ec_d = 1'b1;
            else if (!op_legal(ctl_op))                          eo_d = 1'b1;
            else                                                 fv_d = 1'b1;
        end
    end

    assign frame_start = (state_q != F_COLLECT) && (state_d == F_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_IDLE;
            data_q     <= '0;
            data_cnt_q <= '0;
            idle_cnt_q <= '0;
            bad_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_AND;
            fv_q       <= 1'b0;
            ed_q       <= 1'b0;
            ec_q       <= 1'b0;
            eo_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            fv_q    <= fv_d;
            ed_q    <= ed_d;
            ec_q    <= ec_d;
            eo_q    <= eo_d;
            if (fv_d) begin
                b_q  <= data_q[7:4];
                a_q  <= data_q[3:0];
                op_q <= operation_t'(ctl_op);
            end
            if (frame_start) begin
                data_cnt_q <= '0;
                idle_cnt_q <= '0;
                bad_q      <= 1'b0;
            end else begin
                idle_cnt_q <= idle_tick ? idle_cnt_q + IDLE_W'(1) : '0;
                if (data_pkt) begin
                    if (data_cnt_q < N_DATA)   data_q[~byte_idx] <= pkt_payload;
                    if (data_cnt_q != CNT_SAT) data_cnt_q <= data_cnt_q + 4'd1;
                    if (!pkt_stop_ok || data_cnt_q >= N_DATA) bad_q <= 1'b1;
                end
            end
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign op_out      = op_q;
    assign frame_valid = fv_q;
    assign err_data    = ed_q;
    assign err_crc     = ec_q;
    assign err_op      = eo_q;
    assign busy        = (state_q == F_COLLECT);

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: directed frame table, hand-written
// reset/timeout sequences and randomized frames scored against a frame-level model.
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] a_out, b_out;
    logic [2:0]  op_out;
    logic        frame_valid, err_data, err_crc, err_op, busy;

    alu_serial_rx #(.DATA_PACKETS(8), .IDLE_TIMEOUT(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .a_out       (a_out),
        .b_out       (b_out),
        .op_out      (op_out),
        .frame_valid (frame_valid),
        .err_data    (err_data),
        .err_crc     (err_crc),
        .err_op      (err_op),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [3:0] K_VALID = 4'b1000;
    localparam logic [3:0] K_DATA  = 4'b0100;
    localparam logic [3:0] K_CRC   = 4'b0010;
    localparam logic [3:0] K_OP    = 4'b0001;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } ev_t;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc_x;
        int          n_data;
        int          bad_idx;
        logic        ctl_stop;
        int          gap;
        int          mid_at;
        int          mid_gap;
        logic [3:0]  exp;
    } vec_t;

    ev_t         act_q[$];
    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic [2:0]  exp_op = '0;
    vec_t        tbl[16];

    always @(negedge clk)
        if (rst_n && (frame_valid | err_data | err_crc | err_op))
            act_q.push_back('{32'(cyc), {frame_valid, err_data, err_crc, err_op}, a_out, b_out, op_out});

    // Polynomial long division of {B, A, 1, op} * x^4 by x^4 + x + 1.
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [3:0] model_kind(input vec_t v);
        if (v.n_data != 8 || v.bad_idx >= 0 || !v.ctl_stop) return K_DATA;
        if (v.crc_x != 4'h0) return K_CRC;
        if (!(v.op inside {3'b000, 3'b001, 3'b100, 3'b101})) return K_OP;
        return K_VALID;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(p[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input vec_t v, output int stop_cyc);
        logic [63:0] words;
        logic [7:0]  by;
        logic [3:0]  crc;
        words = {v.b, v.a};
        repeat (v.gap) send_bit(1'b1);
        for (int i = 0; i < v.n_data; i++) begin
            if (i < 8) by = words[63 - 8*i -: 8];
            else       by = 8'hA5;
            send_pkt(1'b0, by, (i == v.bad_idx) ? 1'b0 : 1'b1);
            if (i == 0) check("busy mid-frame", 64'(busy), 64'd1);
            if (i == v.mid_at) repeat (v.mid_gap) send_bit(1'b1);
        end
        crc = ref_crc(v.b, v.a, v.op) ^ v.crc_x;
        send_pkt(1'b1, {1'b0, v.op, crc}, v.ctl_stop);
        stop_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v, input logic [3:0] kind);
        int sc;
        send_frame(v, sc);
        if (kind == K_VALID) begin
            exp_a  = v.a;
            exp_b  = v.b;
            exp_op = v.op;
        end
        exp_q.push_back('{32'(sc + 1), kind, exp_a, exp_b, exp_op});
    endtask

    task automatic compare_events(input string name);
        ev_t e, g;
        repeat (3) send_bit(1'b1);
        #1;
        check({name, " event count"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s event: got cyc=%0d kind=%b a=%h b=%h op=%b expected cyc=%0d kind=%b a=%h b=%h op=%b",
                         name, g.cyc, g.kind, g.a, g.b, g.op, e.cyc, e.kind, e.a, e.b, e.op);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   r;

        repeat (2) @(negedge clk);
        check("reset frame_valid", 64'(frame_valid), 64'd0);
        check("reset err_data", 64'(err_data), 64'd0);
        check("reset err_crc", 64'(err_crc), 64'd0);
        check("reset err_op", 64'(err_op), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset a_out", 64'(a_out), 64'd0);
        check("reset b_out", 64'(b_out), 64'd0);
        check("reset op_out", 64'(op_out), 64'd0);
        rst_n = 1'b1;

        //         B             A             op      crc_x  n  bad ctl  gap mid_at gap   expected
        tbl[0]  = '{32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0, 8, -1, 1'b1, 2, -1, 0,  K_VALID};
        tbl[1]  = '{32'h0000_0003, 32'h0000_0005, 3'b100, 4'h1, 8, -1, 1'b1, 0, -1, 0,  K_CRC};
        tbl[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 4'h0, 8, -1, 1'b1, 0, -1, 0,  K_OP};
        tbl[3]  = '{32'h1111_2222, 32'h3333_4444, 3'b100, 4'h0, 7, -1, 1'b1, 1, -1, 0,  K_DATA};
        tbl[4]  = '{32'h1111_2222, 32'h3333_4444, 3'b100, 4'h0, 9, -1, 1'b1, 0, -1, 0,  K_DATA};
        tbl[5]  = '{32'h0BAD_0BAD, 32'h5555_AAAA, 3'b001, 4'h0, 8,  2, 1'b1, 3, -1, 0,  K_DATA};
        tbl[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0, 8, -1, 1'b1, 0, -1, 0,  K_VALID};
        tbl[7]  = '{32'hCAFE_F00D, 32'h0000_0001, 3'b000, 4'h0, 8, -1, 1'b0, 0, -1, 0,  K_DATA};
        tbl[8]  = '{32'hA5A5_0F0F, 32'h0000_0001, 3'b001, 4'h0, 8, -1, 1'b1, 0, -1, 0,  K_VALID};
        tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 3'b000, 4'h0, 8, -1, 1'b1, 1, -1, 0,  K_VALID};
        tbl[10] = '{32'h1111_1111, 32'h2222_2222, 3'b111, 4'h0, 8, -1, 1'b1, 0, -1, 0,  K_OP};
        tbl[11] = '{32'hDEAD_BEEF, 32'h0123_4567, 3'b100, 4'h0, 8, -1, 1'b1, 1,  4, 31, K_VALID};
        tbl[12] = '{32'h7777_8888, 32'h9999_AAAA, 3'b101, 4'h0, 8, -1, 1'b1, 1,  4, 32, K_DATA};
        tbl[13] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 4'h0, 8, -1, 1'b1, 1, -1, 0,  K_VALID};
        tbl[14] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b011, 4'h8, 8, -1, 1'b1, 0, -1, 0,  K_CRC};
        tbl[15] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b100, 4'h5, 7, -1, 1'b1, 0, -1, 0,  K_DATA};

        for (int i = 0; i < 16; i++) run_vec(tbl[i], tbl[i].exp);
        compare_events("table");

        // Reset after the fourth data packet: partial frame vanishes silently.
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'(8'h21 * (i + 1)), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("busy in reset", 64'(busy), 64'd0);
        check("a_out in reset", 64'(a_out), 64'd0);
        check("op_out in reset", 64'(op_out), 64'd0);
        exp_a  = '0;
        exp_b  = '0;
        exp_op = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_events("reset abort");
        run_vec(tbl[6], K_VALID);
        compare_events("after reset");

        // Long idle after packet five: silent abort.
        for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'(8'h13 * (i + 1)), 1'b1);
        repeat (40) send_bit(1'b1);
        check("busy after timeout", 64'(busy), 64'd0);
        compare_events("timeout");
        run_vec(tbl[0], K_VALID);
        compare_events("after timeout");

        for (int n = 0; n < 40; n++) begin
            v.b        = $urandom;
            v.a        = $urandom;
            v.op       = 3'($urandom_range(0, 7));
            v.crc_x    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            r          = int'($urandom_range(0, 9));
            v.n_data   = (r == 0) ? 7 : (r == 1) ? 9 : 8;
            v.bad_idx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            v.ctl_stop = ($urandom_range(0, 19) != 0);
            v.gap      = int'($urandom_range(0, 3));
            v.mid_at   = -1;
            v.mid_gap  = 0;
            v.exp      = model_kind(v);
            run_vec(v, v.exp);
        end
        compare_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
